// File: rtl/cache_read_reply_packetizer.sv
// Read-reply packetizer: queues completed cache reads as full reply packets
// and emits them toward the requester over a valid/ready link.
module cache_read_reply_packetizer #(
  parameter  int DATA_WIDTH     = 32,
  parameter  int NET_ADDR_WIDTH = 4,
  parameter  int FIFO_DEPTH     = 4,
  parameter  int NODE_ADDRESS   = 0,
  localparam int PKT_WIDTH      = 2 + 2*NET_ADDR_WIDTH + DATA_WIDTH,
  localparam int PTR_WIDTH      = $clog2(FIFO_DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      read_ready_in,
  input  logic [NET_ADDR_WIDTH-1:0] requester_addr_in,
  input  logic [DATA_WIDTH-1:0]     cache_data_in,
  output logic                      pkt_valid,
  input  logic                      pkt_ready,
  output logic [PKT_WIDTH-1:0]      pkt_data,
  output logic [PTR_WIDTH:0]        occupancy,
  output logic                      fifo_full,
  output logic                      overflow,
  output logic [7:0]                drop_count
);

  localparam logic [1:0]                PKT_TYPE  = 2'b10;
  localparam logic [NET_ADDR_WIDTH-1:0] SRC_ADDR  = NET_ADDR_WIDTH'(NODE_ADDRESS);
  localparam logic [PTR_WIDTH:0]        DEPTH_CNT = (PTR_WIDTH+1)'(FIFO_DEPTH);

  logic [PKT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic                 pop;
  logic                 accept;
  logic                 drop;
  logic [PKT_WIDTH-1:0] new_pkt;

  assign new_pkt   = {PKT_TYPE, requester_addr_in, SRC_ADDR, cache_data_in};
  assign pkt_valid = (occupancy != '0);
  assign fifo_full = (occupancy == DEPTH_CNT);
  assign pkt_data  = pkt_valid ? mem[rd_ptr] : '0;

  // A full FIFO still accepts a push when a pop frees a slot on the same edge.
  assign pop    = pkt_valid && pkt_ready;
  assign accept = read_ready_in && (!fifo_full || pop);
  assign drop   = read_ready_in && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (!reset && accept)
      mem[wr_ptr] <= new_pkt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occupancy  <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (accept)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 8'hFF)
          drop_count <= drop_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cache_read_reply_packetizer.sv
// Directed bench for cache_read_reply_packetizer with a packet scoreboard
// and a small occupancy/overflow model.
module tb_cache_read_reply_packetizer;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 4;
  localparam int PW    = 2 + 2*AW + DW;

  logic          clk = 1'b0;
  logic          reset;
  logic          read_ready_in;
  logic [AW-1:0] requester_addr_in;
  logic [DW-1:0] cache_data_in;
  logic          pkt_valid;
  logic          pkt_ready;
  logic [PW-1:0] pkt_data;
  logic [2:0]    occupancy;
  logic          fifo_full;
  logic          overflow;
  logic [7:0]    drop_count;

  int errors = 0;
  int checks = 0;

  logic [PW-1:0] sb[$];
  int            model_occ;
  logic          model_ovf;
  int            model_drop;

  cache_read_reply_packetizer #(
    .DATA_WIDTH(DW), .NET_ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .NODE_ADDRESS(5)
  ) dut (
    .clk(clk), .reset(reset), .read_ready_in(read_ready_in),
    .requester_addr_in(requester_addr_in), .cache_data_in(cache_data_in),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_data(pkt_data),
    .occupancy(occupancy), .fifo_full(fifo_full), .overflow(overflow),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Compares every visible output against the model, including the head packet
  // on every cycle so that a stalled pkt_data is checked for stability.
  task automatic checkOutput(input string tag);
    check({tag, ".occupancy"}, 64'(occupancy), 64'(model_occ));
    check({tag, ".pkt_valid"}, 64'(pkt_valid), 64'(model_occ != 0));
    check({tag, ".fifo_full"}, 64'(fifo_full), 64'(model_occ == DEPTH));
    check({tag, ".overflow"}, 64'(overflow), 64'(model_ovf));
    check({tag, ".drop_count"}, 64'(drop_count), 64'(model_drop));
    if (model_occ != 0)
      check({tag, ".pkt_data"}, 64'(pkt_data), 64'(sb[0]));
    else
      check({tag, ".pkt_data_idle"}, 64'(pkt_data), 64'd0);
  endtask

  // Drives one cycle of inputs at the falling edge, updates the model for the
  // coming rising edge, then samples the DUT at the next falling edge.
  task automatic applyStimulus(input string tag, input logic rst, input logic rr,
                               input logic [AW-1:0] addr, input logic [DW-1:0] data,
                               input logic rdy);
    logic pop_m;
    reset             = rst;
    read_ready_in     = rr;
    requester_addr_in = addr;
    cache_data_in     = data;
    pkt_ready         = rdy;
    if (rst) begin
      sb.delete();
      model_occ  = 0;
      model_ovf  = 1'b0;
      model_drop = 0;
    end else begin
      pop_m = (model_occ != 0) && rdy;
      if (pop_m) begin
        void'(sb.pop_front());
        model_occ--;
      end
      if (rr) begin
        if (model_occ < DEPTH) begin
          sb.push_back({2'b10, addr, 4'h5, data});
          model_occ++;
        end else begin
          model_ovf = 1'b1;
          if (model_drop != 255) model_drop++;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    checkOutput(tag);
  endtask

  initial begin
    model_occ  = 0;
    model_ovf  = 1'b0;
    model_drop = 0;
    reset = 1'b1; read_ready_in = 1'b0; requester_addr_in = '0;
    cache_data_in = '0; pkt_ready = 1'b0;
    @(negedge clk);

    $display("[TB] reset");
    applyStimulus("reset", 1'b1, 1'b0, 4'h0, 32'h0, 1'b0);

    $display("[TB] single reply");
    applyStimulus("single_push", 1'b0, 1'b1, 4'h3, 32'hDEADBEEF, 1'b1);
    check("single_pkt_const", 64'(pkt_data), 64'({2'b10, 4'h3, 4'h5, 32'hDEADBEEF}));
    applyStimulus("single_pop", 1'b0, 1'b0, 4'h0, 32'h0, 1'b1);
    applyStimulus("single_idle", 1'b0, 1'b0, 4'h0, 32'h0, 1'b1);

    $display("[TB] back-pressure and ordering");
    for (int i = 1; i <= 3; i++)
      applyStimulus("bp_push", 1'b0, 1'b1, 4'h2, DW'(i), 1'b0);
    applyStimulus("bp_stall", 1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++)
      applyStimulus("bp_drain", 1'b0, 1'b0, 4'h0, 32'h0, 1'b1);

    $display("[TB] overflow");
    for (int i = 10; i <= 15; i++)
      applyStimulus("ovf_push", 1'b0, 1'b1, 4'h7, DW'(i), 1'b0);
    check("ovf_drop_const", 64'(drop_count), 64'd2);
    for (int i = 0; i < 5; i++)
      applyStimulus("ovf_drain", 1'b0, 1'b0, 4'h0, 32'h0, 1'b1);

    $display("[TB] full with simultaneous push and pop");
    applyStimulus("full_reset", 1'b1, 1'b0, 4'h0, 32'h0, 1'b0);
    for (int i = 20; i <= 23; i++)
      applyStimulus("full_fill", 1'b0, 1'b1, 4'h9, DW'(i), 1'b0);
    applyStimulus("full_pushpop", 1'b0, 1'b1, 4'hA, 32'd24, 1'b1);
    for (int i = 0; i < 5; i++)
      applyStimulus("full_drain", 1'b0, 1'b0, 4'h0, 32'h0, 1'b1);

    $display("[TB] wrap-around");
    for (int i = 0; i < 10; i++)
      applyStimulus("wrap_push", 1'b0, 1'b1, AW'(i), 32'hA5A50000 + DW'(i), 1'b1);
    applyStimulus("wrap_idle", 1'b0, 1'b0, 4'h0, 32'h0, 1'b1);

    $display("[TB] empty with simultaneous push and pop");
    applyStimulus("empty_pushpop", 1'b0, 1'b1, 4'hC, 32'h12345678, 1'b1);
    applyStimulus("empty_pop", 1'b0, 1'b0, 4'h0, 32'h0, 1'b1);

    $display("[TB] reset mid-operation");
    for (int i = 0; i < 5; i++)
      applyStimulus("mid_fill", 1'b0, 1'b1, 4'hE, 32'h100 + DW'(i), 1'b0);
    applyStimulus("mid_pop", 1'b0, 1'b0, 4'h0, 32'h0, 1'b1);
    check("mid_occ_const", 64'(occupancy), 64'd3);
    applyStimulus("mid_reset", 1'b1, 1'b1, 4'hF, 32'hCAFEF00D, 1'b1);
    applyStimulus("mid_after", 1'b0, 1'b0, 4'h0, 32'h0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_read_reply_packetizer.md
Name: cache_read_reply_packetizer

Overview:
- Downstream of the per-router cache access arbiter; one instance per router port (N/S/E/W).
- Captures each completed cache read (ready strobe, requester network address, read data) and queues it in a small FIFO.
- Emits read-reply packets toward the requester over the router output port, using a valid/ready handshake.
- Absorbs back-to-back read completions while the network link is back-pressured; counts and flags any reply lost to overflow.

Parameters:
- DATA_WIDTH, 32, width of the cache read data word.
- NET_ADDR_WIDTH, 4, width of a network node address.
- FIFO_DEPTH, 4, number of reply entries. Must be a power of 2 and ≥2.
- NODE_ADDRESS, 0, network address of this router, inserted as the packet source.
- PKT_WIDTH, 2+2*NET_ADDR_WIDTH+DATA_WIDTH, derived value; must not be overridden.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- read_ready_in  in  1  a read result for this port is present this cycle.
- requester_addr_in  in  NET_ADDR_WIDTH  network address of the node that issued the read.
- cache_data_in  in  DATA_WIDTH  read data word.
- pkt_valid  out  1  pkt_data holds a valid reply packet.
- pkt_ready  in  1  downstream link accepts the packet this cycle.
- pkt_data  out  PKT_WIDTH  packet {type[1:0]=2'b10, dest=requester, src=NODE_ADDRESS, data}, MSB first.
- occupancy  out  clog2(FIFO_DEPTH)+1  number of queued entries.
- fifo_full  out  1  occupancy == FIFO_DEPTH.
- overflow  out  1  sticky; a reply was dropped since the last reset.
- drop_count  out  8  number of dropped replies, saturating at 255.

Behaviour:
- Reset: all outputs and internal state go to 0 on the rising edge where reset=1. This covers pkt_valid, pkt_data, occupancy, fifo_full, overflow, drop_count, read pointer and write pointer.
- Reset mid-operation: all queued entries are discarded. A read_ready_in or pkt_ready asserted in the same cycle as reset is ignored.
- Push: at a rising edge with read_ready_in=1, requester_addr_in and cache_data_in are sampled together and written at wr_ptr. The packet fields are formed at write time, and the entry stores the full packet.
- Pop: a transfer occurs at a rising edge where pkt_valid=1 and pkt_ready=1. rd_ptr advances by one.
- pkt_valid = (occupancy != 0).
- pkt_data = entry at rd_ptr when pkt_valid=1, otherwise all zeros.
- pkt_data must stay stable while pkt_valid=1 and pkt_ready=0.
- pkt_ready while pkt_valid=0 has no effect.
- Latency: a reply pushed at edge N drives pkt_valid=1 from edge N until its pop edge, provided the FIFO was empty before edge N. There is no fall-through within a cycle.
- Ordering: strict FIFO. Replies leave in the order their read_ready_in edges occurred.
- Pointers: wrap modulo FIFO_DEPTH, i.e. natural roll-over of a clog2(FIFO_DEPTH)-bit counter.
- occupancy: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Full, push and pop in the same edge: both occur. The push is accepted and occupancy stays at FIFO_DEPTH.
- Full, push without pop: the new reply is dropped and the FIFO is unchanged. overflow is set and drop_count increments unless it is already 255.
- Empty, push and pop in the same edge: the pop is ignored because pkt_valid was 0. The push is accepted and occupancy becomes 1.
- overflow and drop_count clear only on reset.
- No combinational path from read_ready_in or pkt_ready to any output. pkt_data and pkt_valid depend only on registered state.

Test Plan:
- Single reply. Setup: NODE_ADDRESS=4'h5, FIFO empty, pkt_ready=1. Stimulus: read_ready_in=1 for one edge with requester=4'h3, data=32'hDEADBEEF. Required: pkt_valid=1 for exactly one cycle with pkt_data={2'b10,4'h3,4'h5,32'hDEADBEEF}; occupancy goes 1 then 0; no overflow.
- Back-pressure and ordering. Stimulus: pkt_ready=0; push data 1, 2, 3 on consecutive edges; then pkt_ready=1. Required: occupancy reaches 3; pkt_data holds data 1 throughout the stall; packets emerge as 1, 2, 3 on three consecutive edges.
- Overflow. Stimulus: pkt_ready=0; push 6 replies (data 10..15). Required: fifo_full=1 after the 4th push; overflow=1; drop_count=2; after releasing pkt_ready, output is data 10..13 only.
- Full with simultaneous push and pop. Stimulus: FIFO holds 4 entries; pkt_ready=1 and read_ready_in=1 on the same edge. Required: occupancy stays 4, overflow stays 0, and the new entry emerges 4th.
- Wrap-around. Stimulus: 10 replies pushed one per edge with pkt_ready=1 throughout. Required: all 10 delivered in order with data intact across the pointer roll-over; occupancy never exceeds 1.
- Reset mid-operation. Stimulus: 3 entries queued with overflow=1, then assert reset for one edge together with read_ready_in=1. Required: pkt_valid=0, occupancy=0, overflow=0, drop_count=0, and the coincident reply is not queued.
